// File: rtl/float_sum_of_products_if.sv
// float_sum_of_products_if: argument/result bundle for the sequenced FP sum-of-products block
//   master : drives arg_vld, x, y, neg; observes res_vld, res, res_negative, err, busy
//   slave  : the accumulator side of the same signals
interface float_sum_of_products_if #(
   parameter int FLEN   = 64,
   parameter int NTERMS = 2
);
   logic                   arg_vld;
   logic [NTERMS*FLEN-1:0] x;
   logic [NTERMS*FLEN-1:0] y;
   logic [NTERMS-1:0]      neg;
   logic                   res_vld;
   logic [FLEN-1:0]        res;
   logic                   res_negative;
   logic                   err;
   logic                   busy;
   modport master (output arg_vld, x, y, neg, input res_vld, res, res_negative, err, busy);
   modport slave  (input arg_vld, x, y, neg, output res_vld, res, res_negative, err, busy);
endinterface

// File: rtl/float_sum_of_products.sv
// float_sum_of_products: res = sum_i (neg[i] ? -1 : +1) * x[i] * y[i], one shared multiplier and adder
//   clk  : rising-edge clock
//   rst  : synchronous reset, active low
//   bus  : slave side of float_sum_of_products_if (arg_vld/x/y/neg in; res_vld/res/res_negative/err/busy out)
// The multiplier and adder are single-register-stage units (result one cycle after issue),
// round-to-nearest-even, subnormals flushed to zero, overflow reported as a unit error.
module float_sum_of_products #(
   parameter int FLEN   = 64,
   parameter int NTERMS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   float_sum_of_products_if.slave bus
);
   localparam int IW   = $clog2(NTERMS + 1);
   localparam int EW   = (FLEN == 64) ? 11 : (FLEN == 32) ? 8 : 5;
   localparam int MW   = FLEN - 1 - EW;
   localparam int BIAS = (1 << (EW - 1)) - 1;
   localparam int W    = 2 * MW + 5;
   localparam int SW   = EW + 3;
   localparam logic signed [SW-1:0] EMAX = SW'((1 << EW) - 1);

   typedef enum logic [2:0] {IDLE, MUL, MWAIT, ADD, AWAIT, DONE} state_t;

   // Round and pack; e is the biased exponent of the leading 1. Returns {overflow, value}.
   function automatic logic [FLEN:0] pack(input logic s, input logic signed [SW-1:0] e,
                                          input logic [MW-1:0] m, input logic g, input logic st);
      logic [EW+MW-1:0] r;
      if (e <= 0) return {1'b0, s, {(FLEN-1){1'b0}}};
      if (e >= EMAX) return {1'b1, s, {EW{1'b1}}, {MW{1'b0}}};
      // a mantissa carry from rounding ripples straight into the exponent field
      r = {e[EW-1:0], m} + (EW+MW)'(g & (st | m[0]));
      if (&r[EW+MW-1:MW]) return {1'b1, s, {EW{1'b1}}, {MW{1'b0}}};
      return {1'b0, s, r};
   endfunction

   function automatic logic [FLEN:0] fmul(input logic [FLEN-1:0] a, input logic [FLEN-1:0] b);
      logic [2*MW+1:0]        p;
      logic signed [SW-1:0]   e;
      if (a[FLEN-2:MW] == 0 || b[FLEN-2:MW] == 0) return {1'b0, a[FLEN-1] ^ b[FLEN-1], {(FLEN-1){1'b0}}};
      p = (2*MW+2)'({1'b1, a[MW-1:0]}) * (2*MW+2)'({1'b1, b[MW-1:0]});
      e = SW'(a[FLEN-2:MW]) + SW'(b[FLEN-2:MW]) - SW'(BIAS) + SW'(p[2*MW+1]);
      if (!p[2*MW+1]) p = p << 1;
      return pack(a[FLEN-1] ^ b[FLEN-1], e, p[2*MW:MW+1], p[MW], |p[MW-1:0]);
   endfunction

   function automatic logic [FLEN:0] fadd(input logic [FLEN-1:0] a, input logic [FLEN-1:0] b);
      logic [FLEN-1:0]      h, l;
      logic [EW-1:0]        d;
      logic [W-1:0]         t, xb, sm;
      logic signed [SW-1:0] e;
      int                   lz;
      if (a[FLEN-2:MW] == 0 && b[FLEN-2:MW] == 0) return {1'b0, a[FLEN-1] & b[FLEN-1], {(FLEN-1){1'b0}}};
      if (a[FLEN-2:MW] == 0) return {1'b0, b};
      if (b[FLEN-2:MW] == 0) return {1'b0, a};
      {h, l} = (a[FLEN-2:0] >= b[FLEN-2:0]) ? {a, b} : {b, a};
      d  = h[FLEN-2:MW] - l[FLEN-2:MW];
      t  = {1'b0, 1'b1, l[MW-1:0], {(MW+3){1'b0}}};
      xb = t >> d;
      // bits shifted out collapse into a sticky LSB
      xb[0] = xb[0] | ((xb << d) != t);
      sm = (h[FLEN-1] ^ l[FLEN-1]) ? {1'b0, 1'b1, h[MW-1:0], {(MW+3){1'b0}}} - xb
                                   : {1'b0, 1'b1, h[MW-1:0], {(MW+3){1'b0}}} + xb;
      if (sm == 0) return '0;
      lz = 0;
      for (int i = 0; i < W; i++) if (sm[i]) lz = W - 1 - i;
      sm = sm << lz;
      e  = SW'(h[FLEN-2:MW]) + SW'(1) - SW'(lz);
      return pack(h[FLEN-1], e, sm[W-2 -: MW], sm[W-2-MW], |sm[W-3-MW:0]);
   endfunction

   state_t                 state_q, state_d;
   logic [NTERMS*FLEN-1:0] x_q, x_d, y_q, y_d;
   logic [NTERMS-1:0]      neg_q, neg_d, negs;
   logic [IW-1:0]          idx_q, idx_d;
   logic [FLEN-1:0]        acc_q, acc_d, p_q, p_d, res_q, res_d, xs, ys, pp;
   logic [FLEN:0]          mr_q, mr_d, ar_q, ar_d;
   logic                   mv_q, mv_d, av_q, av_d;
   logic                   err_acc_q, err_acc_d, err_q, err_d, res_neg_q, res_neg_d, res_vld_q, res_vld_d;
   logic                   busy, bad;

   // busy covers the result-strobe cycle too, so the earliest re-accept is the cycle after res_vld
   assign busy             = (state_q != IDLE) || res_vld_q;
   assign bus.busy         = busy;
   assign bus.res_vld      = res_vld_q;
   assign bus.res          = res_q;
   assign bus.res_negative = res_neg_q;
   assign bus.err          = err_q;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      neg_d     = neg_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      p_d       = p_q;
      err_acc_d = err_acc_q;
      res_d     = res_q;
      res_neg_d = res_neg_q;
      err_d     = err_q;
      res_vld_d = 1'b0;
      bad       = 1'b0;
      for (int i = 0; i < NTERMS; i++) bad = bad | (&bus.x[i*FLEN+MW +: EW]) | (&bus.y[i*FLEN+MW +: EW]);
      xs        = FLEN'(x_q >> (FLEN * idx_q));
      ys        = FLEN'(y_q >> (FLEN * idx_q));
      negs      = neg_q >> idx_q;
      pp        = mr_q[FLEN-1:0] ^ {negs[0], {(FLEN-1){1'b0}}};
      mr_d      = fmul(xs, ys);
      mv_d      = (state_q == MUL);
      ar_d      = fadd(acc_q, p_q);
      av_d      = (state_q == ADD);
      case (state_q)
         IDLE: if (bus.arg_vld && !busy) begin
            x_d       = bus.x;
            y_d       = bus.y;
            neg_d     = bus.neg;
            idx_d     = '0;
            err_acc_d = bad;
            state_d   = bad ? DONE : MUL;
         end
         MUL:  state_d = MWAIT;
         MWAIT: if (mv_q) begin
            err_acc_d = err_acc_q | mr_q[FLEN];
            if (idx_q == 0) begin
               acc_d   = pp;
               idx_d   = idx_q + 1'b1;
               state_d = (NTERMS == 1) ? DONE : MUL;
            end else begin
               p_d     = pp;
               state_d = ADD;
            end
         end
         ADD:  state_d = AWAIT;
         AWAIT: if (av_q) begin
            acc_d     = ar_q[FLEN-1:0];
            err_acc_d = err_acc_q | ar_q[FLEN];
            idx_d     = idx_q + 1'b1;
            state_d   = (idx_q == IW'(NTERMS - 1)) ? DONE : MUL;
         end
         DONE: begin
            res_d     = err_acc_q ? '0 : acc_q;
            res_neg_d = ~err_acc_q & acc_q[FLEN-1];
            err_d     = err_acc_q;
            res_vld_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         neg_q     <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         p_q       <= '0;
         err_acc_q <= 1'b0;
         res_q     <= '0;
         res_neg_q <= 1'b0;
         err_q     <= 1'b0;
         res_vld_q <= 1'b0;
         mr_q      <= '0;
         mv_q      <= 1'b0;
         ar_q      <= '0;
         av_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         neg_q     <= neg_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         p_q       <= p_d;
         err_acc_q <= err_acc_d;
         res_q     <= res_d;
         res_neg_q <= res_neg_d;
         err_q     <= err_d;
         res_vld_q <= res_vld_d;
         mr_q      <= mr_d;
         mv_q      <= mv_d;
         ar_q      <= ar_d;
         av_q      <= av_d;
      end
   end
endmodule
